bof_range_tracker: RTL
======================

// Module: bof_range_tracker
// PURPOSE
//  Parametrised heap-overflow detector beside branch_unit in EX. Groups consecutive non-frame stores into runs.
//  Runs of at least MIN_RUN_BYTES are committed to a DEPTH-entry circular range table.
//  A load hitting a tracked range taints the next indirect jump; that jump raises crash_o, which forces the PC target to 0.
// PARAMETERS
//  ADDR_W        32  address width
//  DEPTH          8  range-table entries (power of 2, >=2)
//  CNT_W         16  run byte-counter width (saturating)
//  MIN_RUN_BYTES 32  minimum run length to commit (run_bytes >= MIN_RUN_BYTES)
//  TIMEOUT       10  valid non-store ops tolerated before an open run closes (1..255)
//  TAINT_WINDOW   4  valid ops a taint survives without a jump (1..255)
// PORTS
//  clk_i          in   1          clock
//  rst_ni         in   1          reset, asynchronous, active-low
//  flush_i        in   1          synchronous clear of table, tracker and taint
//  en_i           in   1          crash enable; 0 masks crash_o only, tracking continues
//  op_valid_i     in   1          op presented this cycle
//  op_kind_i      in   2          00 other, 01 store, 10 load, 11 indirect jump (JALR)
//  op_size_i      in   4          store/load size in bytes: 1, 2, 4 or 8
//  op_frame_i     in   1          base register is sp/fp; such stores are ignored
//  op_addr_i      in   ADDR_W     effective address (store/load) or jump target
//  active_o       out  1          run open (state TRACK)
//  run_start_o    out  ADDR_W     open run first byte
//  run_end_o      out  ADDR_W     open run exclusive end (next expected address)
//  tbl_count_o    out  clog2(DEPTH+1)  valid table entries
//  evict_o        out  1          pulse: commit overwrote the oldest entry
//  load_hit_o     out  1          registered: last load hit a table entry or the open run
//  crash_o        out  1          pulse: tainted indirect jump
//  crash_addr_o   out  ADDR_W     target of the crashing jump; holds until next crash
// BEHAVIOUR
//  Reset and flush: every output is 0; state IDLE; wr_ptr=0; all entries invalid; taint=0. flush_i overrides any op in the same cycle.
//  Tracker FSM (a "store" below is a valid, non-frame store):
//   IDLE  - store: go to TRACK; start=end_x=addr; end_x+=size; bytes=size; timer=TIMEOUT.
//   TRACK - store with addr==end_x and end_x+size not wrapping past 2^ADDR_W: extend end_x, bytes+=size, timer=TIMEOUT.
//         - any other store: close the run (commit if bytes>=MIN), then open a new run from this store in the same cycle; stay TRACK.
//         - valid non-store op with timer!=0: timer-=1.
//         - valid non-store op with timer==0: close the run (commit if long enough); go to IDLE.
//         - invalid cycles leave the timer unchanged.
//  Commit: entry[wr_ptr] gets {start,end_x,valid} at the same clock edge; wr_ptr wraps mod DEPTH.
//   If the entry was already valid, evict_o pulses one cycle and tbl_count_o stays at DEPTH.
//  bytes saturates at 2^CNT_W-1.
//  Hit test (comb): start<=addr<end_x, unsigned, against all valid entries plus the open run.
//   Applies to the run state before this cycle's update.
//  Taint: each valid load writes taint=hit, window=TAINT_WINDOW; load_hit_o=hit at the next edge. A non-hitting load clears taint.
//   Each other valid op while tainted decrements window; taint clears when window reaches 0.
//  Jump: valid kind 11 with taint=1 gives crash_o=en_i next cycle, crash_addr_o<=op_addr_i. Any jump clears taint.
//   A jump in the same cycle as a load sees the old taint. Latency load->taint 1 cycle; jump->crash_o 1 cycle.
//  Frame stores and op_size_i values outside {1,2,4,8} count as "other" ops.
//  Reset mid-run discards the open run.
// TESTING
//  SW x8 at 0x1000,+4..0x101C, then LW (other) -> one commit at timeout; tbl_count_o=1, entry [0x1000,0x1020).
//  Same 8 stores, then LW 0x1010, then JALR -> load_hit_o=1, then crash_o=1, crash_addr_o=JALR target; with en_i=0, crash_o stays 0.
//  4 SW 0x2000..0x200C, then SW 0x3000 -> run dropped (16<32), new run start 0x3000; tbl_count_o=0.
//  DEPTH+1 qualifying runs -> evict_o pulses on the last commit; oldest range no longer hits.
//  LW hit, then TAINT_WINDOW ALU ops, then JALR -> no crash. LW hit, then JALR with flush_i in that cycle -> no crash, table empty.
//  Store run ending at 0xFFFFFFFC, then SW 0x0 (size 4) -> no wrap extension; 0x0 starts a new run.

Source files
------------

// File: rtl/bof_range_tracker.sv
// bof_range_tracker: groups contiguous non-frame stores into runs, records long runs in a circular
// range table, and flags an indirect jump that follows a load from a tracked range.
module bof_range_tracker #(
    parameter int ADDR_W        = 32,
    parameter int DEPTH         = 8,
    parameter int CNT_W         = 16,
    parameter int MIN_RUN_BYTES = 32,
    parameter int TIMEOUT       = 10,
    parameter int TAINT_WINDOW  = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       en_i,
    input  logic                       op_valid_i,
    input  logic [1:0]                 op_kind_i,
    input  logic [3:0]                 op_size_i,
    input  logic                       op_frame_i,
    input  logic [ADDR_W-1:0]          op_addr_i,
    output logic                       active_o,
    output logic [ADDR_W-1:0]          run_start_o,
    output logic [ADDR_W-1:0]          run_end_o,
    output logic [$clog2(DEPTH+1)-1:0] tbl_count_o,
    output logic                       evict_o,
    output logic                       load_hit_o,
    output logic                       crash_o,
    output logic [ADDR_W-1:0]          crash_addr_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] MIN_B = CNT_W'(MIN_RUN_BYTES);
    localparam logic [7:0] TO = 8'(TIMEOUT);
    localparam logic [7:0] TW = 8'(TAINT_WINDOW);

    typedef enum logic {IDLE, TRACK} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_start, r_end, r_crash_addr;
    logic [ADDR_W-1:0] r_tbl_start [DEPTH];
    logic [ADDR_W-1:0] r_tbl_end   [DEPTH];
    logic [DEPTH-1:0]  r_tbl_valid;
    logic [PW-1:0]     r_wr_ptr;
    logic [CW-1:0]     r_count;
    logic [CNT_W-1:0]  r_bytes;
    logic [7:0]        r_timer, r_window;
    logic              r_taint, r_load_hit, r_evict, r_crash;

    logic              w_store, w_load, w_jump, w_other, w_extend, w_close, w_commit, w_hit;
    logic [ADDR_W:0]   w_sum;
    logic [CNT_W:0]    w_bsum;
    logic [CNT_W-1:0]  w_bnext;

    assign w_store  = op_valid_i && op_kind_i == 2'b01 && !op_frame_i && op_size_i inside {4'd1, 4'd2, 4'd4, 4'd8};
    assign w_load   = op_valid_i && op_kind_i == 2'b10;
    assign w_jump   = op_valid_i && op_kind_i == 2'b11;
    assign w_other  = op_valid_i && !w_load && !w_jump;
    assign w_sum    = {1'b0, r_end} + (ADDR_W+1)'(op_size_i);
    assign w_bsum   = {1'b0, r_bytes} + (CNT_W+1)'(op_size_i);
    assign w_bnext  = w_bsum[CNT_W] ? '1 : w_bsum[CNT_W-1:0];
    // a run whose end already wrapped to 0 (end <= start) can never be extended
    assign w_extend = r_state == TRACK && op_addr_i == r_end && !w_sum[ADDR_W] && r_end > r_start;
    assign w_close  = r_state == TRACK && ((w_store && !w_extend) || (op_valid_i && !w_store && r_timer == 8'd0));
    assign w_commit = w_close && r_bytes >= MIN_B;

    always_comb begin
        w_hit = r_state == TRACK && op_addr_i >= r_start && op_addr_i < r_end;
        for (int i = 0; i < DEPTH; i++)
            w_hit = w_hit | (r_tbl_valid[i] && op_addr_i >= r_tbl_start[i] && op_addr_i < r_tbl_end[i]);
    end

    always_ff @(posedge clk_i) begin
        if (w_commit && !flush_i) begin
            r_tbl_start[r_wr_ptr] <= r_start;
            r_tbl_end[r_wr_ptr]   <= r_end;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            {r_start, r_end, r_crash_addr} <= '0;
            {r_tbl_valid, r_wr_ptr, r_count, r_bytes, r_timer, r_window} <= '0;
            {r_taint, r_load_hit, r_evict, r_crash} <= '0;
        end else if (flush_i) begin
            r_state <= IDLE;
            {r_start, r_end, r_crash_addr} <= '0;
            {r_tbl_valid, r_wr_ptr, r_count, r_bytes, r_timer, r_window} <= '0;
            {r_taint, r_load_hit, r_evict, r_crash} <= '0;
        end else begin
            r_evict <= 1'b0;
            r_crash <= 1'b0;
            if (w_commit) begin
                r_tbl_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr <= r_wr_ptr + PW'(1);
                r_evict  <= r_tbl_valid[r_wr_ptr];
                r_count  <= r_tbl_valid[r_wr_ptr] ? r_count : r_count + CW'(1);
            end
            if (w_store && !w_extend) begin
                r_state <= TRACK;
                r_start <= op_addr_i;
                r_end   <= op_addr_i + ADDR_W'(op_size_i);
                r_bytes <= CNT_W'(op_size_i);
                r_timer <= TO;
            end else if (w_store) begin
                r_end   <= w_sum[ADDR_W-1:0];
                r_bytes <= w_bnext;
                r_timer <= TO;
            end else if (op_valid_i && r_state == TRACK) begin
                r_state <= r_timer == 8'd0 ? IDLE : TRACK;
                r_timer <= r_timer == 8'd0 ? r_timer : r_timer - 8'd1;
            end
            if (w_load) begin
                r_taint    <= w_hit;
                r_window   <= TW;
                r_load_hit <= w_hit;
            end else if (w_jump) begin
                r_taint <= 1'b0;
                r_crash <= r_taint && en_i;
                if (r_taint && en_i) r_crash_addr <= op_addr_i;
            end else if (w_other && r_taint) begin
                r_window <= r_window - 8'd1;
                r_taint  <= r_window != 8'd1;
            end
        end
    end

    assign active_o     = r_state == TRACK;
    assign run_start_o  = r_start;
    assign run_end_o    = r_end;
    assign tbl_count_o  = r_count;
    assign evict_o      = r_evict;
    assign load_hit_o   = r_load_hit;
    assign crash_o      = r_crash;
    assign crash_addr_o = r_crash_addr;
endmodule
